instr_fetch_stage: RTL and testbench

//  Fetch stage and IF/ID pipeline register. Drives the instruction-memory request,

---
 rtl/instr_fetch_stage_if.sv | 29 ++
 rtl/instr_fetch_stage.sv | 118 +++++++++++
 tb/tb_instr_fetch_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and the decode stage.
// imem_req/imem_ack: the request is held with a stable address until the ack cycle; ack may arrive in the same cycle as req.
interface instr_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump_taken;
    logic [25:0] jump_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  stall, jump_taken, jump_target,
        output if_id_valid, if_id_instr, if_id_pc4, opcode
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output stall, jump_taken, jump_target,
        input  if_id_valid, if_id_instr, if_id_pc4, opcode
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage plus IF/ID register: one-entry hold buffer for decode stalls and
// J redirects that drop the in-flight fetch.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_stage_if.master        bus,
    output logic [1:0]                 fsm_state
);
    typedef enum logic [1:0] {START, FETCH, HOLD, DROP} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] drop_addr, drop_addr_nx;
    logic [31:0] buf_instr, buf_instr_nx;
    logic [31:0] buf_pc4, buf_pc4_nx;
    logic        v_q, v_nx;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] pc4_q, pc4_nx;
    logic [31:0] pc_plus4;
    logic [31:0] jump_pc;
    logic        jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= START;
            pc        <= RESET_PC;
            drop_addr <= 32'h0;
            buf_instr <= NOP_INSTR;
            buf_pc4   <= 32'h0;
            v_q       <= 1'b0;
            instr_q   <= NOP_INSTR;
            pc4_q     <= 32'h0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            drop_addr <= drop_addr_nx;
            buf_instr <= buf_instr_nx;
            buf_pc4   <= buf_pc4_nx;
            v_q       <= v_nx;
            instr_q   <= instr_nx;
            pc4_q     <= pc4_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        drop_addr_nx = drop_addr;
        buf_instr_nx = buf_instr;
        buf_pc4_nx   = buf_pc4;
        v_nx         = v_q;
        instr_nx     = instr_q;
        pc4_nx       = pc4_q;
        bus.imem_req = 1'b0;
        pc_plus4     = pc + 32'd4;
        // A jump only comes from a real instruction sitting in IF/ID.
        jump         = bus.jump_taken && !bus.stall && v_q;
        jump_pc      = {pc4_q[31:28], bus.jump_target, 2'b00};
        case (state)
            START: state_nx = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                if (jump) begin
                    pc_nx    = jump_pc;
                    v_nx     = 1'b0;
                    instr_nx = NOP_INSTR;
                    if (!bus.imem_ack) begin
                        drop_addr_nx = pc;
                        state_nx     = DROP;
                    end
                end else if (bus.stall) begin
                    if (bus.imem_ack) begin
                        buf_instr_nx = bus.imem_rdata;
                        buf_pc4_nx   = pc_plus4;
                        pc_nx        = pc_plus4;
                        state_nx     = HOLD;
                    end
                end else if (bus.imem_ack) begin
                    v_nx     = 1'b1;
                    instr_nx = bus.imem_rdata;
                    pc4_nx   = pc_plus4;
                    pc_nx    = pc_plus4;
                end else begin
                    v_nx     = 1'b0;
                    instr_nx = NOP_INSTR;
                end
            end
            HOLD: begin
                if (jump) begin
                    pc_nx    = jump_pc;
                    v_nx     = 1'b0;
                    instr_nx = NOP_INSTR;
                    state_nx = FETCH;
                end else if (!bus.stall) begin
                    v_nx     = 1'b1;
                    instr_nx = buf_instr;
                    pc4_nx   = buf_pc4;
                    state_nx = FETCH;
                end
            end
            DROP: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) state_nx = FETCH;
            end
        endcase
    end

    // DROP keeps presenting the abandoned address until memory answers it.
    assign bus.imem_addr   = (state == DROP) ? drop_addr : pc;
    assign bus.if_id_valid = v_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.opcode      = instr_q[31:26];
    assign fsm_state       = state;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, reset/wrap/jump sequences,
// then random memory latency, stalls and jumps against a program-order model.
module tb_instr_fetch_stage;
  logic clk;
  logic reset;
  logic [1:0] fsm0, fsm_w, fsm_j;
  int n_cmp;
  int n_err;

  instr_fetch_stage_if bus0();
  instr_fetch_stage_if busw();
  instr_fetch_stage_if busj();

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus0), .fsm_state(fsm0));
  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_w (
    .clk(clk), .reset(reset), .bus(busw), .fsm_state(fsm_w));
  instr_fetch_stage #(.RESET_PC(32'h1000_0004), .NOP_INSTR(32'h0000_0000)) dut_j (
    .clk(clk), .reset(reset), .bus(busj), .fsm_state(fsm_j));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        jump;
    logic [25:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[20];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus0.imem_ack = 1'b0; bus0.imem_rdata = 32'h0; bus0.stall = 1'b0;
    bus0.jump_taken = 1'b0; bus0.jump_target = 26'h0;
    busw.imem_ack = 1'b0; busw.imem_rdata = 32'h0; busw.stall = 1'b0;
    busw.jump_taken = 1'b0; busw.jump_target = 26'h0;
    busj.imem_ack = 1'b0; busj.imem_rdata = 32'h0; busj.stall = 1'b0;
    busj.jump_taken = 1'b0; busj.jump_target = 26'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic fill_vecs();
    //           ack   rdata         stl   jmp   tgt       req   addr          vld   instr         pc4
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 26'h0,   1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 32'hA022_0004, 1'b0, 1'b0, 26'h0,  1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 32'h8C22_0008, 1'b1, 1'b0, 26'h0,  1'b1, 32'h4,        1'b1, 32'hA022_0004, 32'h4};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 26'h0,   1'b0, 32'h0,        1'b1, 32'hA022_0004, 32'h4};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 26'h0,   1'b0, 32'h0,        1'b1, 32'hA022_0004, 32'h4};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 26'h0,   1'b0, 32'h0,        1'b1, 32'hA022_0004, 32'h4};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 26'h20,  1'b1, 32'h8,        1'b1, 32'h8C22_0008, 32'h8};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 26'h0,   1'b1, 32'h8,        1'b0, 32'h0,        32'h8};
    vecs[8]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 26'h0,  1'b1, 32'h8,        1'b0, 32'h0,        32'h8};
    vecs[9]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 26'h0,  1'b1, 32'h80,       1'b0, 32'h0,        32'h8};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 26'h0,   1'b1, 32'h84,       1'b1, 32'h1234_5678, 32'h84};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 26'h0,   1'b1, 32'h84,       1'b0, 32'h0,        32'h84};
    vecs[12] = '{1'b1, 32'h2108_0001, 1'b0, 1'b0, 26'h0,  1'b1, 32'h84,       1'b0, 32'h0,        32'h84};
    vecs[13] = '{1'b1, 32'h3C01_1000, 1'b0, 1'b1, 26'h3,  1'b1, 32'h88,       1'b1, 32'h2108_0001, 32'h88};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 26'h3,   1'b1, 32'hC,        1'b0, 32'h0,        32'h88};
    vecs[15] = '{1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 26'h0,  1'b1, 32'hC,        1'b0, 32'h0,        32'h88};
    vecs[16] = '{1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 26'h0,  1'b1, 32'h10,       1'b1, 32'hAAAA_0001, 32'h10};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 26'h100, 1'b0, 32'h0,        1'b1, 32'hAAAA_0001, 32'h10};
    vecs[18] = '{1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 26'h0,  1'b1, 32'h400,      1'b0, 32'h0,        32'h10};
    vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 26'h0,   1'b1, 32'h404,      1'b1, 32'hCCCC_0003, 32'h404};
  endtask

  // random phase state
  logic        outstanding;
  logic [31:0] out_addr;
  int          lat;
  logic [31:0] exp_pc;
  logic [63:0] e;
  int          consumed;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    fill_vecs();

    // directed vector table on dut (RESET_PC = 0)
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ei;
      logic ok;
      ei = vecs[i].e_instr;
      ok = (bus0.imem_req === vecs[i].e_req) &&
           (!vecs[i].e_req || bus0.imem_addr === vecs[i].e_addr) &&
           (bus0.if_id_valid === vecs[i].e_valid) &&
           (bus0.if_id_instr === vecs[i].e_instr) &&
           (bus0.if_id_pc4 === vecs[i].e_pc4) &&
           (bus0.opcode === ei[31:26]);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b addr=%h v=%b instr=%h pc4=%h op=%b expected req=%b addr=%h v=%b instr=%h pc4=%h op=%b",
                 i, bus0.imem_req, bus0.imem_addr, bus0.if_id_valid, bus0.if_id_instr, bus0.if_id_pc4, bus0.opcode,
                 vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc4, ei[31:26]);
      end
      bus0.imem_ack   = vecs[i].ack;
      bus0.imem_rdata = vecs[i].rdata;
      bus0.stall      = vecs[i].stall;
      bus0.jump_taken = vecs[i].jump;
      bus0.jump_target = vecs[i].tgt;
      @(negedge clk);
    end

    // asynchronous reset while in HOLD
    do_reset();
    bus0.imem_ack = 1'b0;
    @(negedge clk);
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'h0101_0101; bus0.stall = 1'b0;
    @(negedge clk);
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'h0202_0202; bus0.stall = 1'b1;
    @(negedge clk);
    bus0.imem_ack = 1'b0;
    chk("hold_state", {62'h0, fsm0}, 64'd2);
    chk("hold_valid", {63'h0, bus0.if_id_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", {63'h0, bus0.imem_req}, 64'd0);
    chk("async_rst_if_id", {bus0.if_id_valid, bus0.if_id_instr, bus0.if_id_pc4[30:0]}, 64'd0);
    chk("async_rst_pc4", {32'h0, bus0.if_id_pc4}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus0.stall = 1'b0;
    chk("post_rst_start_req", {63'h0, bus0.imem_req}, 64'd0);
    @(negedge clk);
    chk("post_rst_fetch", {31'h0, bus0.imem_req, bus0.imem_addr}, {31'h0, 1'b1, 32'h0});

    // pc wrap on dut_w and same-cycle-ack jump on dut_j
    do_reset();
    @(negedge clk);
    chk("wrap_addr", {31'h0, busw.imem_req, busw.imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    chk("jreg_addr", {31'h0, busj.imem_req, busj.imem_addr}, {31'h0, 1'b1, 32'h1000_0004});
    busw.imem_ack = 1'b1; busw.imem_rdata = 32'h1111_2222;
    busj.imem_ack = 1'b1; busj.imem_rdata = 32'h0800_0010;
    @(negedge clk);
    busw.imem_ack = 1'b0;
    chk("wrap_if_id", {busw.if_id_instr, busw.if_id_pc4}, {32'h1111_2222, 32'h0});
    chk("wrap_next_addr", {26'h0, busw.opcode, busw.imem_addr}, {26'h0, 6'b000100, 32'h0});
    chk("wrap_state", {62'h0, fsm_w}, 64'd1);
    chk("jreg_if_id", {busj.if_id_instr, busj.if_id_pc4}, {32'h0800_0010, 32'h1000_0008});
    chk("jreg_opcode", {58'h0, busj.opcode}, {58'h0, 6'b000010});
    busj.imem_ack = 1'b1; busj.imem_rdata = 32'hFFFF_FFFF;
    busj.jump_taken = 1'b1; busj.jump_target = 26'h10;
    @(negedge clk);
    busj.imem_ack = 1'b0; busj.jump_taken = 1'b0;
    chk("jump_addr", {31'h0, busj.imem_req, busj.imem_addr}, {31'h0, 1'b1, 32'h1000_0040});
    chk("jump_bubble", {31'h0, busj.if_id_valid, busj.if_id_instr}, 64'd0);
    chk("jump_state", {62'h0, fsm_j}, 64'd1);

    // random: memory with 0..2 cycle latency, random stalls and jumps
    do_reset();
    outstanding = 1'b0;
    out_addr = 32'h0;
    lat = 0;
    consumed = 0;
    exp_pc = 32'h0;
    exp_q.delete();
    exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic ack, stall, jump;
      logic [25:0] tgt;
      if (bus0.imem_req) begin
        n_cmp++;
        if (bus0.imem_addr[1:0] !== 2'b00) begin
          n_err++;
          $display("FAIL rnd_align: got addr %h required low bits 00", bus0.imem_addr);
        end
      end
      if (outstanding) begin
        n_cmp++;
        if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== out_addr) begin
          n_err++;
          $display("FAIL rnd_req_hold: got req=%b addr=%h required req=1 addr=%h",
                   bus0.imem_req, bus0.imem_addr, out_addr);
        end
      end else if (bus0.imem_req) begin
        outstanding = 1'b1;
        out_addr = bus0.imem_addr;
        lat = $urandom_range(0, 2);
      end
      ack = outstanding && (lat == 0);
      if (outstanding && !ack) lat--;
      stall = ($urandom_range(0, 3) == 0);
      jump  = bus0.if_id_valid && !stall && ($urandom_range(0, 7) == 0);
      tgt   = 26'($urandom);
      if (bus0.if_id_valid && !stall) begin
        consumed++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_queue: got instr %h with empty expected queue", bus0.if_id_instr);
        end else begin
          e = exp_q.pop_front();
          if ({bus0.if_id_instr, bus0.if_id_pc4} !== e || bus0.opcode !== e[63:58]) begin
            n_err++;
            $display("FAIL rnd_instr: got instr=%h pc4=%h op=%b expected instr=%h pc4=%h op=%b",
                     bus0.if_id_instr, bus0.if_id_pc4, bus0.opcode, e[63:32], e[31:0], e[63:58]);
          end
          exp_pc = jump ? {e[31:28], tgt, 2'b00} : e[31:0];
          exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        end
      end else if (!bus0.if_id_valid) begin
        chk("rnd_bubble", {32'h0, bus0.if_id_instr}, 64'd0);
      end
      bus0.imem_ack    = ack;
      bus0.imem_rdata  = ack ? mem_word(out_addr) : $urandom;
      bus0.stall       = stall;
      bus0.jump_taken  = jump;
      bus0.jump_target = tgt;
      @(posedge clk);
      if (ack) outstanding = 1'b0;
      @(negedge clk);
    end
    chk("rnd_progress", {63'h0, consumed >= 300}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
